md_sched: RTL and testbench

- Multiply/divide sequencer for the E stage of the 5-stage pipeline.
- Accepts mult/multu/div/divu from E, latches the operands, and holds BUSY for a fixed per-op latency before committing HI/LO.
- Handles mthi/mtlo writes.
- Generates the stall request that freezes F/D and bubbles D/E (so the E/M register receives nops) while a HI/LO-dependent instruction sits in D.

---
 rtl/md_sched_if.sv | 25 ++
 rtl/md_sched.sv | 115 +++++++++++
 tb/tb_md_sched.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// E/D-stage handshake between the pipeline and the multiply/divide sequencer.
interface md_sched_if;
  logic        start_E;
  logic [1:0]  op_E;
  logic [31:0] a_E;
  logic [31:0] b_E;
  logic        mthi_E;
  logic        mtlo_E;
  logic [31:0] wdata_E;
  logic        md_use_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start_E, op_E, a_E, b_E, mthi_E, mtlo_E, wdata_E, md_use_D,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start_E, op_E, a_E, b_E, mthi_E, mtlo_E, wdata_E, md_use_D,
    output busy, stall_md, hi, lo
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide sequencer: latches operands, holds busy for a fixed
// per-op latency, then commits HI/LO; also services mthi/mtlo and D-stage stalls.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  md
);
  // state  | meaning
  // S_IDLE | no operation in flight; accepts start and moves
  // S_RUN  | operation in flight; counting down to commit
  typedef enum logic {S_IDLE, S_RUN} state_e;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            commit;

  logic [63:0]     prod_s, prod_u;
  logic [31:0]     a_mag, b_mag, b_div, uq, ur, q_s, r_s, q_u, r_u;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md.start_E) begin
          state_d = S_RUN;
          cnt_d   = md.op_E[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          op_d    = md.op_E;
          a_d     = md.a_E;
          b_d     = md.b_E;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Signed divide via magnitudes: truncation toward zero and a remainder that
  // follows the dividend fall out directly, and 0x80000000 / -1 yields 0x80000000 r 0.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
    b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
    b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq     = a_mag / b_div;
    ur     = a_mag % b_div;
    q_s    = (a_q[31] ^ b_q[31]) ? (~uq + 32'd1) : uq;
    r_s    = a_q[31] ? (~ur + 32'd1) : ur;
    q_u    = a_q / ((b_q == 32'd0) ? 32'd1 : b_q);
    r_u    = a_q % ((b_q == 32'd0) ? 32'd1 : b_q);
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      case (op_q)
        2'b00: {hi_d, lo_d} = prod_s;
        2'b01: {hi_d, lo_d} = prod_u;
        2'b10: if (b_q != 32'd0) begin hi_d = r_s; lo_d = q_s; end
        default: if (b_q != 32'd0) begin hi_d = r_u; lo_d = q_u; end
      endcase
    end else if (state_q == S_IDLE && !md.start_E) begin
      if (md.mthi_E) hi_d = md.wdata_E;
      if (md.mtlo_E) lo_d = md.wdata_E;
    end
  end

  assign md.busy     = (state_q == S_RUN);
  assign md.stall_md = md.md_use_D & (md.start_E | md.busy);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected HI/LO and latency are queued at issue
// and compared when busy drops.
module tb_md_sched;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  md_sched_if bus ();
  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic idle_inputs();
    bus.start_E  = 1'b0;
    bus.op_E     = 2'b00;
    bus.a_E      = '0;
    bus.b_E      = '0;
    bus.mthi_E   = 1'b0;
    bus.mtlo_E   = 1'b0;
    bus.wdata_E  = '0;
  endtask

  task automatic do_move(input logic wr_hi, input logic wr_lo, input logic [31:0] d);
    @(negedge clk);
    bus.mthi_E  = wr_hi;
    bus.mtlo_E  = wr_lo;
    bus.wdata_E = d;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // inj: 0 none, 1 mtlo 0x1234 during RUN, 2 new start during RUN
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic use_d, input logic mv_with_start,
                       input int inj, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e, got;
    int cnt;
    e.hi = ehi; e.lo = elo; e.n = op[1] ? DIV_N : MULT_N;
    @(negedge clk);
    bus.start_E  = 1'b1;
    bus.op_E     = op;
    bus.a_E      = a;
    bus.b_E      = b;
    bus.md_use_D = use_d;
    bus.mthi_E   = mv_with_start;
    bus.mtlo_E   = mv_with_start;
    bus.wdata_E  = 32'hAAAA_5555;
    sb_q.push_back(e);
    #1 chk({tag, ".stall_issue"}, bus.stall_md, use_d);
    @(posedge clk); #1;
    idle_inputs();
    cnt = 0;
    for (int guard = 0; guard < 40; guard++) begin
      @(negedge clk);
      if (!bus.busy) break;
      cnt++;
      if (bus.stall_md !== use_d) chk({tag, ".stall_run"}, bus.stall_md, use_d);
      if (cnt == 2 && inj == 1) begin
        bus.mtlo_E = 1'b1; bus.wdata_E = 32'h1234;
      end else if (cnt == 2 && inj == 2) begin
        bus.start_E = 1'b1; bus.op_E = 2'b11; bus.a_E = 32'd100; bus.b_E = 32'd3;
      end
      @(posedge clk); #1;
      idle_inputs();
    end
    got = sb_q.pop_front();
    chk({tag, ".busy_cycles"}, cnt, got.n);
    chk({tag, ".stall_after"}, bus.stall_md, 1'b0);
    chk({tag, ".hi"}, bus.hi, got.hi);
    chk({tag, ".lo"}, bus.lo, got.lo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    longint      p;
    int          sq, sr;
    reset = 1'b1;
    idle_inputs();
    bus.md_use_D = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.hi", bus.hi, 32'h0);
    chk("rst.lo", bus.lo, 32'h0);
    chk("rst.stall", bus.stall_md, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    bus.md_use_D = 1'b0;

    do_move(1'b1, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("mthi.hi", bus.hi, 32'hDEAD_BEEF);
    chk("mthi.lo", bus.lo, 32'h0);
    do_move(1'b1, 1'b1, 32'h0000_0055);
    @(negedge clk);
    chk("mvboth.hi", bus.hi, 32'h55);
    chk("mvboth.lo", bus.lo, 32'h55);

    // reset in the middle of a mult discards the result
    @(negedge clk);
    bus.start_E = 1'b1; bus.op_E = 2'b00; bus.a_E = 32'd3; bus.b_E = 32'd4;
    @(posedge clk); #1 idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid.busy", bus.busy, 1'b0);
    chk("rstmid.hi", bus.hi, 32'h0);
    chk("rstmid.lo", bus.lo, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstmid.busy_after", bus.busy, 1'b0);
    chk("rstmid.lo_after", bus.lo, 32'h0);

    do_op("mult",   2'b00, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("multu",  2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 0, 32'h0000_0001, 32'hFFFF_FFFE);
    do_op("div",    2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu",   2'b11, 32'd7,         32'd2, 1'b0, 1'b0, 0, 32'd1,         32'd3);
    do_op("divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 32'h0, 32'h8000_0000);

    do_move(1'b1, 1'b0, 32'h11);
    do_move(1'b0, 1'b1, 32'h22);
    do_op("divu0",  2'b11, 32'd5, 32'd0, 1'b1, 1'b0, 0, 32'h11, 32'h22);
    do_op("div0mv", 2'b10, 32'd9, 32'd0, 1'b0, 1'b1, 0, 32'h11, 32'h22);
    do_op("mtlorun", 2'b00, 32'd3, 32'd4, 1'b1, 1'b0, 1, 32'h0, 32'd12);
    do_op("startrun", 2'b00, 32'd6, 32'd7, 1'b1, 1'b0, 2, 32'h0, 32'd42);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = $urandom();
      if (rb == 32'd0) rb = 32'd1;
      if (ra == 32'h8000_0000) ra = 32'h7FFF_FFFF;
      case (rop)
        2'b00: begin
          p = longint'(int'(ra)) * longint'(int'(rb));
          do_op("rnd_mult", rop, ra, rb, 1'b1, 1'b0, 0, p[63:32], p[31:0]);
        end
        2'b01: begin
          p = longint'({32'd0, ra}) * longint'({32'd0, rb});
          do_op("rnd_multu", rop, ra, rb, 1'b0, 1'b0, 0, p[63:32], p[31:0]);
        end
        2'b10: begin
          sq = int'(ra) / int'(rb);
          sr = int'(ra) % int'(rb);
          do_op("rnd_div", rop, ra, rb, 1'b1, 1'b0, 0, sr, sq);
        end
        default: do_op("rnd_divu", rop, ra, rb, 1'b0, 1'b0, 0, ra % rb, ra / rb);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
